trap_ctrl: RTL and testbench

Machine-mode trap sequencer for the NPC core: detects ecall/ebreak/mret and the pending timer/external interrupt on the instruction in EX, writes mepc/mcause/mstatus over successive cycles through a dedicated CSR write port, and redirects fetch. It drives the pipeline controller's clint inputs (`stallreq_from_clint`, `int_assert_i`, `int_addr_i`). It is the requester side of the stall/flush protocol. The pipeline controller answers `stallreq_o` with a full-pipeline freeze and flush, and answers `int_assert_o` with a flush plus a PC redirect to `int_addr_o`.

---
 rtl/trap_ctrl_if.sv | 33 +++
 rtl/trap_ctrl.sv | 123 ++++++++++++
 tb/tb_trap_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Bundle between the trap sequencer, the EX stage decode/CSR read side and the
// pipeline controller / CSR write port.
interface trap_ctrl_if;
   logic        inst_valid_i;
   logic [31:0] inst_addr_i;
   logic        ecall_i;
   logic        ebreak_i;
   logic        mret_i;
   logic        irq_i;
   logic [31:0] mstatus_i;
   logic [31:0] mtvec_i;
   logic [31:0] mepc_i;
   logic        stallreq_o;
   logic        int_assert_o;
   logic [31:0] int_addr_o;
   logic        csr_we_o;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o;

   modport slave (
      input  inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i, irq_i,
      input  mstatus_i, mtvec_i, mepc_i,
      output stallreq_o, int_assert_o, int_addr_o,
      output csr_we_o, csr_waddr_o, csr_wdata_o
   );

   modport master (
      output inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i, irq_i,
      output mstatus_i, mtvec_i, mepc_i,
      input  stallreq_o, int_assert_o, int_addr_o,
      input  csr_we_o, csr_waddr_o, csr_wdata_o
   );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes ecall/ebreak/mret/irq from EX, writes
// mepc/mcause/mstatus one per cycle, then pulses a fetch redirect.
module trap_ctrl #(
   parameter logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC
) (
   input  logic        clk,
   input  logic        rst_n,
   trap_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_W_MEPC, S_W_MCAUSE, S_W_MSTATUS, S_W_MRET, S_ASSERT
   } state_t;

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;

   state_t      r_state;
   logic [31:0] r_cause;
   logic [31:0] r_ms;
   logic [31:0] r_target;
   logic        r_stall;
   logic        r_int_assert;
   logic [31:0] r_int_addr;
   logic        r_csr_we;
   logic [11:0] r_csr_waddr;
   logic [31:0] r_csr_wdata;

   logic        w_sel;
   logic        w_trap;
   logic        w_mret;
   logic [31:0] w_cause;

   // Trap entry: MPIE <= MIE, MIE <= 0.
   function automatic logic [31:0] ms_on_trap(input logic [31:0] ms);
      return (ms & ~32'h0000_0088) | {24'b0, ms[3], 7'b0};
   endfunction

   // Trap return: MIE <= MPIE, MPIE <= 1.
   function automatic logic [31:0] ms_on_mret(input logic [31:0] ms);
      return (ms & ~32'h0000_0088) | 32'h0000_0080 | {28'b0, ms[7], 3'b0};
   endfunction

   // Detection is gated by rst_n so the combinational stall stays low in reset.
   assign w_sel   = rst_n && (r_state == S_IDLE) && bus.inst_valid_i;
   assign w_trap  = w_sel && (bus.ecall_i || bus.ebreak_i ||
                              (!bus.mret_i && bus.irq_i && bus.mstatus_i[3]));
   assign w_mret  = w_sel && bus.mret_i && !bus.ecall_i && !bus.ebreak_i;
   assign w_cause = bus.ecall_i  ? 32'd11 :
                    bus.ebreak_i ? 32'd3  : 32'h8000_0007;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cause      <= '0;
         r_ms         <= '0;
         r_target     <= '0;
         r_stall      <= 1'b0;
         r_int_assert <= 1'b0;
         r_int_addr   <= '0;
         r_csr_we     <= 1'b0;
         r_csr_waddr  <= '0;
         r_csr_wdata  <= '0;
      end else begin
         r_stall      <= 1'b0;
         r_int_assert <= 1'b0;
         r_int_addr   <= '0;
         r_csr_we     <= 1'b0;
         r_csr_waddr  <= '0;
         r_csr_wdata  <= '0;
         // Outputs are registered: each arm loads what the next state drives.
         case (r_state)
            S_IDLE: begin
               if (w_trap) begin
                  r_cause     <= w_cause;
                  r_ms        <= bus.mstatus_i;
                  r_target    <= bus.mtvec_i & MTVEC_MASK;
                  r_state     <= S_W_MEPC;
                  r_stall     <= 1'b1;
                  r_csr_we    <= 1'b1;
                  r_csr_waddr <= A_MEPC;
                  r_csr_wdata <= bus.inst_addr_i;
               end else if (w_mret) begin
                  r_ms        <= bus.mstatus_i;
                  r_target    <= bus.mepc_i;
                  r_state     <= S_W_MRET;
                  r_stall     <= 1'b1;
                  r_csr_we    <= 1'b1;
                  r_csr_waddr <= A_MSTATUS;
                  r_csr_wdata <= ms_on_mret(bus.mstatus_i);
               end
            end
            S_W_MEPC: begin
               r_state     <= S_W_MCAUSE;
               r_stall     <= 1'b1;
               r_csr_we    <= 1'b1;
               r_csr_waddr <= A_MCAUSE;
               r_csr_wdata <= r_cause;
            end
            S_W_MCAUSE: begin
               r_state     <= S_W_MSTATUS;
               r_stall     <= 1'b1;
               r_csr_we    <= 1'b1;
               r_csr_waddr <= A_MSTATUS;
               r_csr_wdata <= ms_on_trap(r_ms);
            end
            S_W_MSTATUS, S_W_MRET: begin
               r_state      <= S_ASSERT;
               r_int_assert <= 1'b1;
               r_int_addr   <= r_target;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.stallreq_o   = r_stall | w_trap | w_mret;
   assign bus.int_assert_o = r_int_assert;
   assign bus.int_addr_o   = r_int_addr;
   assign bus.csr_we_o     = r_csr_we;
   assign bus.csr_waddr_o  = r_csr_waddr;
   assign bus.csr_wdata_o  = r_csr_wdata;
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios then random traffic, all compared
// cycle by cycle against a queue-based model of the expected output stream.
module tb_trap_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   trap_ctrl_if bus ();

   trap_ctrl #(.MTVEC_MASK(32'hFFFF_FFFC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        stall;
      logic        ia;
      logic [31:0] iaddr;
      logic        we;
      logic [11:0] waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] env_mstatus, env_mtvec, env_mepc;
   int          checks   = 0;
   int          failures = 0;

   function automatic exp_t mk(input logic s, input logic ia, input logic [31:0] ad,
                               input logic we, input logic [11:0] wa, input logic [31:0] wd);
      exp_t e;
      e.stall = s; e.ia = ia; e.iaddr = ad; e.we = we; e.waddr = wa; e.wdata = wd;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, advance the model.
   task automatic step(input logic r, input logic v, input logic [31:0] a,
                       input logic ec, input logic eb, input logic mr, input logic iq);
      exp_t        e;
      logic [31:0] cause, ms;
      @(negedge clk);
      rst_n            = r;
      bus.inst_valid_i = v;
      bus.inst_addr_i  = a;
      bus.ecall_i      = ec;
      bus.ebreak_i     = eb;
      bus.mret_i       = mr;
      bus.irq_i        = iq;
      bus.mstatus_i    = env_mstatus;
      bus.mtvec_i      = env_mtvec;
      bus.mepc_i       = env_mepc;
      #1;
      e = mk(0, 0, 0, 0, 0, 0);
      ms = env_mstatus;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
      end else if (r && v) begin
         if (ec || eb || (iq && ms[3] && !mr)) begin
            cause = ec ? 32'd11 : (eb ? 32'd3 : 32'h8000_0007);
            e.stall = 1'b1;
            exp_q.push_back(mk(1, 0, 0, 1, 12'h341, a));
            exp_q.push_back(mk(1, 0, 0, 1, 12'h342, cause));
            exp_q.push_back(mk(1, 0, 0, 1, 12'h300, {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]}));
            exp_q.push_back(mk(0, 1, {env_mtvec[31:2], 2'b00}, 0, 0, 0));
         end else if (mr) begin
            e.stall = 1'b1;
            exp_q.push_back(mk(1, 0, 0, 1, 12'h300, {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]}));
            exp_q.push_back(mk(0, 1, env_mepc, 0, 0, 0));
         end
      end
      chk("stallreq",   bus.stallreq_o,   e.stall);
      chk("int_assert", bus.int_assert_o, e.ia);
      chk("int_addr",   bus.int_addr_o,   e.iaddr);
      chk("csr_we",     bus.csr_we_o,     e.we);
      chk("csr_waddr",  bus.csr_waddr_o,  e.waddr);
      chk("csr_wdata",  bus.csr_wdata_o,  e.wdata);
      if (e.we) begin
         if (e.waddr == 12'h300) env_mstatus = e.wdata;
         if (e.waddr == 12'h341) env_mepc    = e.wdata;
      end
      if (!r) exp_q.delete();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 32'h0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.inst_valid_i = 1'b0;
      bus.inst_addr_i  = '0;
      bus.ecall_i      = 1'b0;
      bus.ebreak_i     = 1'b0;
      bus.mret_i       = 1'b0;
      bus.irq_i        = 1'b0;
      bus.mstatus_i    = '0;
      bus.mtvec_i      = '0;
      bus.mepc_i       = '0;
      env_mstatus = 32'h0;
      env_mtvec   = 32'h0;
      env_mepc    = 32'h0;

      // Reset held with a valid ecall present.
      for (int i = 0; i < 3; i++) step(0, 1, 32'h0000_0100, 1, 0, 0, 0);

      // ecall on the first cycle out of reset.
      env_mstatus = 32'h0000_0008;
      env_mtvec   = 32'h8000_0101;
      step(1, 1, 32'h8000_0010, 1, 0, 0, 0);
      idle(5);

      // irq gated off by MIE=0, then taken once MIE is set; held irq is not re-taken.
      env_mstatus = 32'h0;
      for (int i = 0; i < 10; i++) step(1, 1, 32'h0000_1000 + 4 * i, 0, 0, 0, 1);
      env_mstatus = 32'h0000_0008;
      step(1, 1, 32'h0000_2000, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++) step(1, 1, 32'h0000_2004, 0, 0, 0, 1);

      // mret, then mret together with irq.
      env_mepc    = 32'h8000_0200;
      env_mstatus = 32'h0000_0080;
      step(1, 1, 32'h0000_3000, 0, 0, 1, 0);
      idle(3);
      step(1, 1, 32'h0000_3010, 0, 0, 1, 1);
      idle(3);

      // ecall and irq together with MIE=1; irq held afterwards is not taken.
      env_mstatus = 32'h0000_0008;
      step(1, 1, 32'h0000_4000, 1, 0, 0, 1);
      for (int i = 0; i < 7; i++) step(1, 1, 32'h0000_4004, 0, 0, 0, 1);

      // ebreak with mret also decoded: exception wins.
      env_mstatus = 32'h0000_0088;
      step(1, 1, 32'h0000_4100, 0, 1, 1, 0);
      idle(5);

      // Invalid instruction slot with ecall is ignored.
      step(1, 0, 32'h0000_4200, 1, 0, 0, 1);
      idle(1);

      // Reset at T+2 of a trap, then a clean ebreak.
      env_mstatus = 32'h0000_0008;
      step(1, 1, 32'h0000_5000, 1, 0, 0, 0);
      idle(1);
      step(0, 0, 32'h0, 0, 0, 0, 0);
      idle(4);
      step(1, 1, 32'h0000_6000, 0, 1, 0, 0);
      idle(5);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) env_mtvec   = $urandom;
         if ($urandom_range(0, 9)  == 0) env_mstatus = $urandom;
         step(($urandom_range(0, 59) != 0),
              ($urandom_range(0, 3) != 0),
              {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 2) == 0));
      end
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
